// File: rtl/store_ctrl_if.sv
// Memory write-port bus between the store sequencer (master) and the data
// memory (slave): a req/ack handshake carrying one word-aligned beat.
`ifndef DataBusBits
`define DataBusBits 32
`endif

interface store_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic                    req;
  logic                    ack;
  logic [ADDR_W-1:0]       addr;
  logic [`DataBusBits-1:0] wdata;
  logic [3:0]              be;

  modport master (output req, addr, wdata, be, input ack);
  modport slave  (input req, addr, wdata, be, output ack);
endinterface

// File: rtl/store_ctrl.sv
// Store sequencer: buffers SB/SH/SW requests from execute in a DEPTH-entry
// FIFO and drains them in order onto the word-addressed memory write bus.
// Build option STORE_SPLIT_EN: when defined, stores crossing a word boundary
// are issued as two beats; when undefined they are dropped with st_err.
`ifndef DataBusBits
`define DataBusBits 32
`endif

module store_ctrl #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    st_valid,
  output logic                    st_ready,
  input  logic [2:0]              st_funct3,
  input  logic [ADDR_W-1:0]       st_addr,
  input  logic [`DataBusBits-1:0] st_data,
  output logic                    st_err,
  store_ctrl_if.master            mem,
  output logic                    sb_empty
);

`ifdef STORE_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  localparam int PTR_W = $clog2(DEPTH);

  // size: 0 byte, 1 half, 2 word (funct3[1:0] of a legal store)
  typedef struct packed {
    logic [1:0]        size;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } entry_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, BEAT2} state_t;

  entry_t           sb_mem [DEPTH];
  entry_t           new_entry;
  entry_t           head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic [PTR_W:0]   count_next;
  state_t           state;

  logic             legal;
  logic             accept;
  logic             push;
  logic             pop;
  logic [3:0]       head_mask;
  logic [31:0]      head_rep;
  logic [63:0]      head_rot;
  logic [7:0]       head_be8;
  logic             second_beat;

  assign st_ready = (count != (PTR_W + 1)'(DEPTH));
  assign accept   = st_valid && st_ready;
  assign push     = accept && legal;
  assign sb_empty = (count == '0) && (state == IDLE);

  assign new_entry = '{size: st_funct3[1:0], addr: st_addr, data: st_data[31:0]};
  assign head      = sb_mem[rd_ptr];

  // Legality of the incoming request: funct3 code and, without splitting, alignment.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    legal = 1'b0;
    case (st_funct3)
      3'b000:  legal = 1'b1;
      3'b001:  legal = SPLIT_EN || !st_addr[0];
      3'b010:  legal = SPLIT_EN || (st_addr[1:0] == 2'b00);
      default: legal = 1'b0;
    endcase
  end

  // Lane formation for the head entry: replicate to a word, rotate into the
  // byte lanes of the offset; bits 7:4 of head_be8 are the next word's lanes.
  always_comb begin
    head_mask = 4'b1111;
    head_rep  = head.data;
    case (head.size)
      2'd0: begin
        head_mask = 4'b0001;
        head_rep  = {4{head.data[7:0]}};
      end
      2'd1: begin
        head_mask = 4'b0011;
        head_rep  = {2{head.data[15:0]}};
      end
      default: begin
        head_mask = 4'b1111;
        head_rep  = head.data;
      end
    endcase
    head_be8    = {4'b0000, head_mask} << head.addr[1:0];
    head_rot    = {head_rep, head_rep} << {head.addr[1:0], 3'b000};
    second_beat = SPLIT_EN && (head_be8[7:4] != 4'b0000);
  end

  assign pop = ((state == WAIT) && mem.ack && !second_beat) ||
               ((state == BEAT2) && mem.ack);

  assign count_next = count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};

  // FIFO pointers, occupancy and the one-cycle drop indication.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      st_err <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count  <= count_next;
      st_err <= accept && !legal;
    end
  end

  // Buffer storage write port.
  // NOTE: the storage array has no reset; occupancy is tracked by count, so stale contents are never read.
  always_ff @(posedge clk) begin
    if (push) sb_mem[wr_ptr] <= new_entry;
  end

  // Drain FSM with registered bus outputs; beats hold stable until acked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mem.req   <= 1'b0;
      mem.addr  <= '0;
      mem.wdata <= '0;
      mem.be    <= 4'b0000;
    end else begin
      case (state)
        IDLE: begin
          // Counting a same-cycle push here gives req two cycles after accept.
          if (count_next != '0) state <= ISSUE;
        end
        ISSUE: begin
          mem.req   <= 1'b1;
          mem.addr  <= {head.addr[ADDR_W-1:2], 2'b00};
          mem.wdata <= head_rot[63:32];
          mem.be    <= head_be8[3:0];
          state     <= WAIT;
        end
        WAIT: begin
          if (mem.ack) begin
            if (second_beat) begin
              // Same rotated word; only the lane enables move to the next word.
              mem.addr <= mem.addr + ADDR_W'(4);
              mem.be   <= head_be8[7:4];
              state    <= BEAT2;
            end else begin
              mem.req <= 1'b0;
              state   <= (count_next != '0) ? ISSUE : IDLE;
            end
          end
        end
        BEAT2: begin
          if (mem.ack) begin
            mem.req <= 1'b0;
            state   <= (count_next != '0) ? ISSUE : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_store_ctrl.sv
// Self-checking bench for store_ctrl. A byte-level reference model turns each
// accepted store into the beats the memory should see; a monitor compares
// every acked beat in order. Honours STORE_SPLIT_EN like the design.
`ifndef DataBusBits
`define DataBusBits 32
`endif

module tb_store_ctrl;

`ifdef STORE_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] mask;
  } beat_t;

  logic                    clk;
  logic                    rst_n;
  logic                    st_valid;
  logic                    st_ready;
  logic [2:0]              st_funct3;
  logic [31:0]             st_addr;
  logic [`DataBusBits-1:0] st_data;
  logic                    st_err;
  logic                    sb_empty;

  store_ctrl_if #(.ADDR_W(32)) mem_bus ();

  store_ctrl #(.DEPTH(4), .ADDR_W(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .st_valid (st_valid),
    .st_ready (st_ready),
    .st_funct3(st_funct3),
    .st_addr  (st_addr),
    .st_data  (st_data),
    .st_err   (st_err),
    .mem      (mem_bus),
    .sb_empty (sb_empty)
  );

  int    vectors     = 0;
  int    miscompares = 0;
  beat_t exp_q[$];
  bit    ack_hold    = 1'b0;
  int    pulse_req   = 0;
  int    pulses_done = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // A request is dropped if funct3 is not SB/SH/SW, or (no split) misaligned.
  function automatic bit model_err(input logic [2:0] f3, input logic [31:0] a);
    if (f3 > 3'd2) return 1'b1;
    if (SPLIT) return 1'b0;
    if (f3 == 3'd1) return a[0];
    if (f3 == 3'd2) return a[1:0] != 2'b00;
    return 1'b0;
  endfunction

  // Walk the store byte by byte: byte i lands at address a+i, i.e. word
  // (a+i) & ~3, lane (a+i) % 4. Bytes past lane 3 belong to the next word.
  task automatic model_push(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    beat_t b0, b1;
    int n, o, p, lane;
    if (model_err(f3, a)) return;
    n = 1 << f3;
    o = int'(a[1:0]);
    b0.addr = {a[31:2], 2'b00};
    b1.addr = b0.addr + 32'd4;
    b0.be = 4'b0000; b1.be = 4'b0000;
    b0.wdata = '0;   b1.wdata = '0;
    for (int i = 0; i < n; i++) begin
      p = o + i;
      lane = p % 4;
      if (p < 4) begin
        b0.be[lane] = 1'b1;
        b0.wdata[8*lane +: 8] = d[8*i +: 8];
      end else begin
        b1.be[lane] = 1'b1;
        b1.wdata[8*lane +: 8] = d[8*i +: 8];
      end
    end
    if (!SPLIT) begin
      // Whole word defined: byte/half replicated across lanes, rotated by offset.
      for (int j = 0; j < 4; j++) b0.wdata[8*j +: 8] = d[8*((j - o + 4) % n) +: 8];
      b0.mask = 32'hFFFF_FFFF;
    end else begin
      b0.mask = '0;
      b1.mask = '0;
      for (int j = 0; j < 4; j++) begin
        if (b0.be[j]) b0.mask[8*j +: 8] = 8'hFF;
        if (b1.be[j]) b1.mask[8*j +: 8] = 8'hFF;
      end
    end
    exp_q.push_back(b0);
    if (b1.be != 4'b0000) exp_q.push_back(b1);
  endtask

  // Memory responder: random acks (also while idle), or held low with
  // single requested pulses.
  initial begin
    mem_bus.ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!ack_hold) begin
        mem_bus.ack = 1'($urandom_range(0, 1));
      end else if (pulses_done < pulse_req && mem_bus.req) begin
        mem_bus.ack = 1'b1;
        pulses_done++;
      end else begin
        mem_bus.ack = 1'b0;
      end
    end
  end

  // Beat monitor: every acked beat must match the scoreboard head; an
  // un-acked beat must hold still until it is acked.
  initial begin
    bit          holding;
    logic [31:0] h_addr, h_wdata;
    logic [3:0]  h_be;
    beat_t       e;
    holding = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        holding = 1'b0;
      end else begin
        if (holding) begin
          check("req_held", mem_bus.req, 1'b1);
          check("addr_held", mem_bus.addr, h_addr);
          check("be_held", mem_bus.be, h_be);
          check("wdata_held", mem_bus.wdata, h_wdata);
        end
        if (mem_bus.req && mem_bus.ack) begin
          holding = 1'b0;
          check("beat_expected", exp_q.size() != 0, 1'b1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("mem_addr", mem_bus.addr, e.addr);
            check("mem_be", mem_bus.be, e.be);
            check("mem_wdata", mem_bus.wdata & e.mask, e.wdata & e.mask);
          end
        end else if (mem_bus.req) begin
          holding = 1'b1;
          h_addr  = mem_bus.addr;
          h_be    = mem_bus.be;
          h_wdata = mem_bus.wdata;
        end else begin
          holding = 1'b0;
        end
      end
    end
  end

  // st_err must pulse exactly the cycle after a dropped request is accepted.
  initial begin
    bit pend;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend = 1'b0;
      end else begin
        check("st_err", st_err, pend);
        pend = st_valid && st_ready && model_err(st_funct3, st_addr);
      end
    end
  end

  // Wait (bounded) for the handshake; returns just after the accepting edge.
  task automatic wait_accept();
    bit ok;
    ok = 1'b0;
    for (int w = 0; w < 500; w++) begin
      @(negedge clk);
      if (st_ready) begin
        @(posedge clk);
        model_push(st_funct3, st_addr, st_data[31:0]);
        ok = 1'b1;
        break;
      end
    end
    if (!ok) @(posedge clk);
    #1;
    st_valid = 1'b0;
    check("accept_in_time", ok, 1'b1);
  endtask

  task automatic send(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    st_valid  = 1'b1;
    st_funct3 = f3;
    st_addr   = a;
    st_data   = d;
    wait_accept();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (!(sb_empty && exp_q.size() == 0) && w < 2000) begin
      @(negedge clk);
      w++;
    end
    check("drained_empty", sb_empty && (exp_q.size() == 0), 1'b1);
    idle(1);
  endtask

  logic [2:0]  d_f3   [7] = '{3'd2, 3'd0, 3'd1, 3'd2, 3'd3, 3'd1, 3'd0};
  logic [31:0] d_addr [7] = '{32'h100, 32'h203, 32'h202, 32'h101, 32'h300, 32'h207, 32'h3FF};
  logic [31:0] d_data [7] = '{32'hDEADBEEF, 32'h000000A5, 32'h00001234, 32'h11223344,
                              32'h55555555, 32'h0000ABCD, 32'h0000007E};

  initial begin
    logic [2:0]  f3;
    logic [31:0] a;
    rst_n     = 1'b0;
    st_valid  = 1'b0;
    st_funct3 = 3'd0;
    st_addr   = '0;
    st_data   = '0;

    // Reset values.
    #12;
    check("rst_req", mem_bus.req, 1'b0);
    check("rst_addr", mem_bus.addr, 32'h0);
    check("rst_wdata", mem_bus.wdata, 32'h0);
    check("rst_be", mem_bus.be, 4'b0000);
    check("rst_st_err", st_err, 1'b0);
    check("rst_st_ready", st_ready, 1'b1);
    check("rst_sb_empty", sb_empty, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);

    // Directed stores, including misaligned and illegal funct3.
    send(d_f3[0], d_addr[0], d_data[0]);
    drain();
    for (int i = 1; i < 7; i++) begin
      send(d_f3[i], d_addr[i], d_data[i]);
      idle(i % 2);
    end
    drain();

    // Latency: accept at cycle N, mem_req rises at N+2.
    ack_hold = 1'b1;
    send(3'd2, 32'h400, 32'hCAFEF00D);
    @(negedge clk);
    check("lat_req_n1", mem_bus.req, 1'b0);
    @(negedge clk);
    check("lat_req_n2", mem_bus.req, 1'b1);
    idle(1);
    ack_hold = 1'b0;
    drain();

    // Full buffer: four accepts with no ack, fifth stalls until one ack.
    ack_hold = 1'b1;
    for (int i = 0; i < 4; i++) send(3'd2, 32'h500 + 32'(4 * i), 32'hA0A0_0000 + 32'(i));
    @(negedge clk);
    check("full_not_ready", st_ready, 1'b0);
    @(posedge clk);
    #1;
    st_valid  = 1'b1;
    st_funct3 = 3'd2;
    st_addr   = 32'h510;
    st_data   = 32'hA0A0_0004;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("full_stall", st_ready, 1'b0);
    end
    pulse_req++;
    wait_accept();
    ack_hold = 1'b0;
    drain();

    // Reset mid-beat with three entries queued behind the beat in flight.
    ack_hold = 1'b1;
    for (int i = 0; i < 4; i++) send(3'd2, 32'h600 + 32'(4 * i), $urandom());
    for (int w = 0; w < 20 && !mem_bus.req; w++) @(negedge clk);
    @(negedge clk);
    check("pre_rst_req", mem_bus.req, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_req", mem_bus.req, 1'b0);
    check("midrst_sb_empty", sb_empty, 1'b1);
    check("midrst_st_ready", st_ready, 1'b1);
    exp_q.delete();
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    ack_hold = 1'b0;
    idle(20);
    check("post_rst_sb_empty", sb_empty, 1'b1);
    check("post_rst_no_beats", exp_q.size(), 32'd0);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 200; i++) begin
      f3 = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
      a  = $urandom();
      if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
      send(f3, a, $urandom());
      idle($urandom_range(0, 2));
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
